// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant owner
// and the default bus wait limit.
package types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_IF  = 1'b0,
    ARB_MEM = 1'b1
  } arb_gnt_t;

  localparam int ARB_TIMEOUT = 255;

endpackage

// File: rtl/arb_timer.sv
// Bus wait counter: counts cycles spent in a grant state and flags the
// cycle in which the TIMEOUT-th wait cycle elapses.
module arb_timer #(
  parameter int TIMEOUT = 255,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + W'(1);
    end
  end

  // Completion is registered, so flag one cycle early to land the ack
  // exactly TIMEOUT cycles after bus_req rose.
  assign expired = (count_reg == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arb.sv
// Arbitrates instruction fetch and MEM-stage load/store onto one shared bus,
// alternating under contention and completing with err on bus timeout.
module mem_arb
  import types::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            mem_ack,
  output logic [XLEN-1:0] mem_rdata,
  output logic            err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            stall
);

  arb_state_t      state_reg, state_next;
  arb_gnt_t        last_gnt_reg, last_gnt_next;
  logic            bus_req_next, bus_we_next;
  logic [XLEN-1:0] bus_addr_next, bus_wdata_next;
  logic            if_ack_next, mem_ack_next, err_next;
  logic [XLEN-1:0] if_rdata_next, mem_rdata_next;
  logic            if_pend, mem_pend, done, expired;
  logic [XLEN-1:0] rdata_done;

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .clear   (!rst_n || state_reg == IDLE),
    .enable  (state_reg != IDLE),
    .expired (expired)
  );

  // A requester acked this cycle may still hold req high; do not re-grant it.
  assign if_pend    = if_req & ~if_ack;
  assign mem_pend   = mem_req & ~mem_ack;
  assign done       = bus_ready | expired;
  assign rdata_done = bus_ready ? bus_rdata : '0;
  assign stall      = (mem_req & ~mem_ack) | (if_req & ~if_ack);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_gnt_reg <= ARB_IF;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      if_ack       <= 1'b0;
      mem_ack      <= 1'b0;
      err          <= 1'b0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      bus_req      <= bus_req_next;
      bus_we       <= bus_we_next;
      bus_addr     <= bus_addr_next;
      bus_wdata    <= bus_wdata_next;
      if_ack       <= if_ack_next;
      mem_ack      <= mem_ack_next;
      err          <= err_next;
      if_rdata     <= if_rdata_next;
      mem_rdata    <= mem_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_gnt_next  = last_gnt_reg;
    bus_req_next   = bus_req;
    bus_we_next    = bus_we;
    bus_addr_next  = bus_addr;
    bus_wdata_next = bus_wdata;
    if_ack_next    = 1'b0;
    mem_ack_next   = 1'b0;
    err_next       = 1'b0;
    if_rdata_next  = if_rdata;
    mem_rdata_next = mem_rdata;

    case (state_reg)
      IDLE: begin
        if (mem_pend && (!if_pend || last_gnt_reg == ARB_IF)) begin
          state_next     = GNT_MEM;
          bus_req_next   = 1'b1;
          bus_we_next    = mem_we;
          bus_addr_next  = mem_addr;
          bus_wdata_next = mem_wdata;
        end else if (if_pend) begin
          state_next    = GNT_IF;
          bus_req_next  = 1'b1;
          bus_we_next   = 1'b0;
          bus_addr_next = if_addr;
        end
      end
      GNT_IF: begin
        if (done) begin
          state_next    = IDLE;
          last_gnt_next = ARB_IF;
          bus_req_next  = 1'b0;
          if_ack_next   = 1'b1;
          if_rdata_next = rdata_done;
          err_next      = ~bus_ready;
        end
      end
      GNT_MEM: begin
        if (done) begin
          state_next     = IDLE;
          last_gnt_next  = ARB_MEM;
          bus_req_next   = 1'b0;
          mem_ack_next   = 1'b1;
          mem_rdata_next = bus_we ? '0 : rdata_done;
          err_next       = ~bus_ready;
        end
      end
      default: begin
        state_next   = IDLE;
        bus_req_next = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning address/data width.
REQ-002 SHALL provide parameter TIMEOUT, default 255, meaning maximum bus wait cycles before error completion.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port if_req  input  1  fetch request, held until if_ack.
REQ-006 SHALL have port if_addr  input  XLEN  fetch address, stable while if_req.
REQ-007 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port if_rdata  output  XLEN  fetch data, valid with if_ack.
REQ-009 SHALL have port mem_req  input  1  MEM-stage load/store request, held until mem_ack.
REQ-010 SHALL have port mem_we  input  1  1=store, 0=load.
REQ-011 SHALL have port mem_addr  input  XLEN  data address.
REQ-012 SHALL have port mem_wdata  input  XLEN  store data.
REQ-013 SHALL have port mem_ack  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port mem_rdata  output  XLEN  load data, valid with mem_ack.
REQ-015 SHALL have port err  output  1  timeout flag, valid with if_ack/mem_ack.
REQ-016 SHALL have port bus_req, bus_we  output  1 each  shared-bus request and write enable.
REQ-017 SHALL have port bus_addr, bus_wdata  output  XLEN each  shared-bus address and write data.
REQ-018 SHALL have port bus_ready  input  1  bus completion, one cycle.
REQ-019 SHALL have port bus_rdata  input  XLEN  bus read data, valid with bus_ready.
REQ-020 SHALL have port stall  output  1  combinational hold for IF/ID and EX/MEM pipeline registers.

Function
REQ-021 SHALL implement FSM states IDLE, GNT_IF, GNT_MEM.
REQ-022 IDLE: SHALL go to GNT_MEM if only mem_req, GNT_IF if only if_req, else stay IDLE.
REQ-023 IDLE, both pending: SHALL grant the requester not granted last (last_gnt), making access alternate under contention.
REQ-024 SHALL register all bus_* outputs: request seen in IDLE at cycle N -> bus_req=1 with granted address/data/we at N+1.
REQ-025 SHALL hold bus_* outputs constant while in GNT_* until completion.
REQ-026 GNT_x with bus_ready=1 at cycle M: SHALL at M+1 pulse x_ack, present registered bus_rdata on x_rdata, drive err=0, bus_req=0, state IDLE, last_gnt=x.
REQ-027 SHALL ignore the just-acknowledged requester's req in the ack cycle, so a still-high req is not re-granted; the other requester may be granted that cycle.
REQ-028 SHALL count wait cycles in GNT_*; on reaching TIMEOUT without bus_ready, SHALL complete as REQ-026 with rdata=0 and err=1.
REQ-029 SHALL hold x_rdata stable until the next ack to that requester.
REQ-030 Stores SHALL return mem_rdata=0.
REQ-031 stall SHALL equal (mem_req & ~mem_ack) | (if_req & ~if_ack).
REQ-032 bus_ready in IDLE SHALL be ignored.
REQ-033 Minimum turnaround: one idle bus cycle between consecutive grants.

Reset
REQ-034 While rst_n=0 at a clock edge: state=IDLE, last_gnt=IF, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, if_ack=0, mem_ack=0, err=0, if_rdata=0, mem_rdata=0.
REQ-035 Reset mid-transaction SHALL abandon it without an ack; a late bus_ready after reset is ignored per REQ-032.

Structure
REQ-036 The arb_state_t enum, arb_gnt_t (IF/MEM) and the default ARB_TIMEOUT constant SHALL live in package types.
REQ-037 The wait counter SHALL be a sub-module arb_timer (clear, enable, expired output), width $clog2(TIMEOUT+1).

Verification
REQ-038 Load: mem_req=1, mem_addr=0x100, bus_ready after 3 wait cycles with bus_rdata=0xDEADBEEF -> mem_ack one cycle later, mem_rdata=0xDEADBEEF, err=0.
REQ-039 Contention from reset: if_req and mem_req both high -> MEM granted first, then IF, then MEM; each gap shows one idle bus cycle.
REQ-040 Timeout: if_req=1, bus_ready never -> if_ack and err=1 exactly TIMEOUT cycles after bus_req rose, if_rdata=0.
REQ-041 Store: mem_we=1, mem_wdata=0x12345678 -> bus_we=1, bus_wdata=0x12345678 stable until bus_ready; mem_rdata=0.
REQ-042 Reset: rst_n=0 mid-GNT_IF -> next cycle all outputs at REQ-034 values, no if_ack.
REQ-043 Stall: mem_req held -> stall=1 every cycle until the mem_ack cycle, where stall=0.
